instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 174 +++++++++++++++++
 tb/tb_instr_encoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : Encodes instruction requests into 16-bit words and writes them
//               to consecutive program memory addresses starting at base_addr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] base_addr,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [3:0]                       req_opcode,
  input  logic [3:0]                       req_rd,
  input  logic [3:0]                       req_rs,
  input  logic [3:0]                       req_rt,
  input  logic [2:0]                       req_nzp,
  input  logic [7:0]                       req_imm,
  input  logic                             req_last,
  output logic                             mem_write_valid,
  input  logic                             mem_write_ready,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_write_address,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] mem_write_data,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [PROGRAM_MEM_ADDR_BITS:0]   instr_count
);

  localparam logic [3:0] c_OP_ILLEGAL = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                             state_q, state_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   data_q, data_d;
  logic [PROGRAM_MEM_ADDR_BITS:0]     count_q, count_d;
  logic                               last_q, last_d;
  logic                               error_q, error_d;
  logic [15:0]                        w_enc;

  // Field placement per opcode; fields an opcode does not use stay zero.
  always_comb begin
    w_enc        = 16'h0000;
    w_enc[15:12] = req_opcode;
    case (req_opcode)
      4'b0011, 4'b0100, 4'b0101, 4'b0110: begin
        w_enc[11:8] = req_rd;
        w_enc[7:4]  = req_rs;
        w_enc[3:0]  = req_rt;
      end
      4'b0010, 4'b1000: begin
        w_enc[7:4] = req_rs;
        w_enc[3:0] = req_rt;
      end
      4'b0111: begin
        w_enc[11:8] = req_rd;
        w_enc[7:4]  = req_rs;
      end
      4'b1001: begin
        w_enc[11:8] = req_rd;
        w_enc[7:0]  = req_imm;
      end
      4'b0001, 4'b1011: begin
        w_enc[11:9] = req_nzp;
        w_enc[7:0]  = req_imm;
      end
      4'b1101: w_enc[7:0] = req_imm;
      4'b1010: begin
        w_enc[11:8] = req_rd;
        w_enc[7:4]  = req_rs;
        w_enc[3:1]  = req_nzp;
      end
      default: w_enc[11:0] = 12'h000;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    data_d          = data_q;
    count_d         = count_q;
    last_d          = last_q;
    error_d         = error_q;
    req_ready       = 1'b0;
    mem_write_valid = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCEPT;
          addr_d  = base_addr;
          count_d = '0;
          error_d = 1'b0;
        end
      end
      S_ACCEPT: begin
        req_ready = 1'b1;
        busy      = 1'b1;
        if (req_valid) begin
          if (req_opcode == c_OP_ILLEGAL) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            data_d  = PROGRAM_MEM_DATA_BITS'(w_enc);
            last_d  = req_last;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        mem_write_valid = 1'b1;
        busy            = 1'b1;
        if (mem_write_ready) begin
          count_d = count_q + 1'b1;
          if (last_q) begin
            state_d = S_DONE;
          end else if (&addr_q) begin
            // Top of memory reached without a last instruction: stop, never wrap.
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_ACCEPT;
          end
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      last_q  <= last_d;
      error_q <= error_d;
    end
  end

  assign mem_write_address = addr_q;
  assign mem_write_data    = data_q;
  assign instr_count       = count_q;
  assign error             = error_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed self-checking bench for instr_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_opcode = 4'h0;
  logic [3:0]  req_rd = 4'h0;
  logic [3:0]  req_rs = 4'h0;
  logic [3:0]  req_rt = 4'h0;
  logic [2:0]  req_nzp = 3'h0;
  logic [7:0]  req_imm = 8'h00;
  logic        req_last = 1'b0;
  logic        mem_write_valid;
  logic        mem_write_ready = 1'b0;
  logic [7:0]  mem_write_address;
  logic [15:0] mem_write_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [8:0]  instr_count;

  int n_checks = 0;
  int n_pass   = 0;

  instr_encoder #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_addr         (base_addr),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_opcode        (req_opcode),
    .req_rd            (req_rd),
    .req_rs            (req_rs),
    .req_rt            (req_rt),
    .req_nzp           (req_nzp),
    .req_imm           (req_imm),
    .req_last          (req_last),
    .mem_write_valid   (mem_write_valid),
    .mem_write_ready   (mem_write_ready),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .instr_count       (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load(input logic [7:0] base);
    start     = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
  endtask

  // Present one request and hold it until the DUT accepts it (bounded).
  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [2:0] nzp, input logic [7:0] imm,
                       input logic last);
    bit seen = 0;
    req_opcode = op; req_rd = rd; req_rs = rs; req_rt = rt;
    req_nzp = nzp; req_imm = imm; req_last = last;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        seen = 1;
        break;
      end
      tick();
    end
    if (!seen) check("req_ready_timeout", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Verify a pending write, optionally stalling, then complete it.
  task automatic write_phase(input string tag, input logic [7:0] exp_addr,
                             input logic [15:0] exp_data, input int stall);
    for (int i = 0; i <= stall; i++) begin
      check({tag, "_valid"}, 32'(mem_write_valid), 32'd1);
      check({tag, "_addr"},  32'(mem_write_address), 32'(exp_addr));
      check({tag, "_data"},  32'(mem_write_data), 32'(exp_data));
      check({tag, "_rdy0"},  32'(req_ready), 32'd0);
      if (i < stall) tick();
    end
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_valid", 32'(mem_write_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_addr",  32'(mem_write_address), 32'd0);
    check("rst_data",  32'(mem_write_data), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    reset = 1'b0;
    tick();

    // Single ADD load
    begin_load(8'h10);
    check("acc_ready", 32'(req_ready), 32'd1);
    check("acc_busy",  32'(busy), 32'd1);
    issue(4'h3, 4'd3, 4'd1, 4'd2, 3'b111, 8'hAA, 1'b1);
    write_phase("add", 8'h10, 16'h3312, 0);
    check("add_done",  32'(done), 32'd1);
    check("add_count", 32'(instr_count), 32'd1);
    check("add_error", 32'(error), 32'd0);
    check("add_nowr",  32'(mem_write_valid), 32'd0);
    tick();
    check("add_done1", 32'(done), 32'd0);
    check("add_idle",  32'(busy), 32'd0);

    // Multi-instruction load with unused fields driven non-zero
    begin_load(8'h20);
    issue(4'h1, 4'hF, 4'hF, 4'hF, 3'b010, 8'h25, 1'b0);
    write_phase("br", 8'h20, 16'h1425, 0);
    issue(4'h2, 4'hF, 4'd1, 4'd2, 3'b111, 8'hFF, 1'b0);
    start = 1'b1; base_addr = 8'h55;
    tick();
    start = 1'b0;
    write_phase("cmp", 8'h21, 16'h2012, 0);
    issue(4'hA, 4'd5, 4'd7, 4'hF, 3'b101, 8'hFF, 1'b0);
    write_phase("movc", 8'h22, 16'hA57A, 0);
    issue(4'h9, 4'd2, 4'hF, 4'hF, 3'b111, 8'h7F, 1'b1);
    write_phase("const", 8'h23, 16'h927F, 3);
    check("multi_done",  32'(done), 32'd1);
    check("multi_count", 32'(instr_count), 32'd4);
    tick();

    // Illegal opcode
    begin_load(8'h30);
    issue(4'hE, 4'd1, 4'd1, 4'd1, 3'b000, 8'h00, 1'b1);
    check("ill_done",  32'(done), 32'd1);
    check("ill_error", 32'(error), 32'd1);
    check("ill_nowr",  32'(mem_write_valid), 32'd0);
    check("ill_count", 32'(instr_count), 32'd0);
    tick();
    check("ill_hold",  32'(error), 32'd1);
    check("ill_idle",  32'(busy), 32'd0);
    begin_load(8'hFF);
    check("start_clr_error", 32'(error), 32'd0);

    // Top-of-memory overflow
    issue(4'h3, 4'd1, 4'd2, 4'd3, 3'b000, 8'h00, 1'b0);
    write_phase("top", 8'hFF, 16'h3123, 0);
    req_opcode = 4'h4; req_last = 1'b0; req_valid = 1'b1;
    check("top_done",  32'(done), 32'd1);
    check("top_error", 32'(error), 32'd1);
    check("top_count", 32'(instr_count), 32'd1);
    check("top_rdy0",  32'(req_ready), 32'd0);
    tick();
    check("top_rdy1",  32'(req_ready), 32'd0);
    check("top_nowr",  32'(mem_write_valid), 32'd0);
    req_valid = 1'b0;
    tick();

    // Reset during a stalled write
    begin_load(8'h40);
    issue(4'h4, 4'd1, 4'd2, 4'd3, 3'b000, 8'h00, 1'b0);
    check("rw_valid", 32'(mem_write_valid), 32'd1);
    reset = 1'b1;
    tick();
    check("rw_nowr",  32'(mem_write_valid), 32'd0);
    check("rw_busy",  32'(busy), 32'd0);
    check("rw_ready", 32'(req_ready), 32'd0);
    check("rw_addr",  32'(mem_write_address), 32'd0);
    check("rw_data",  32'(mem_write_data), 32'd0);
    check("rw_count", 32'(instr_count), 32'd0);
    check("rw_error", 32'(error), 32'd0);
    reset = 1'b0;
    tick();
    check("rw_stay_idle", 32'(mem_write_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
